// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS byte-writable registers.
// Writes commit once both address and data are held; reads return one cycle after AR.
module axi4lite_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFFS       = $clog2(STRB_WIDTH);
  localparam int IDXW       = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (OFFS + IDXW)) == {ADDR_WIDTH{1'b0}};
  endfunction

  function automatic logic [IDXW-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
    return a[OFFS +: IDXW];
  endfunction

  logic                                r_aw_held;
  logic                                r_w_held;
  logic [ADDR_WIDTH-1:0]               r_awaddr;
  logic [DATA_WIDTH-1:0]               r_wdata;
  logic [STRB_WIDTH-1:0]               r_wstrb;
  logic                                r_bvalid;
  logic [1:0]                          r_bresp;
  logic                                r_rvalid;
  logic [1:0]                          r_rresp;
  logic [DATA_WIDTH-1:0]               r_rdata;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
  logic [NUM_REGS-1:0]                 r_wr_pulse;

  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_ar_hs;
  logic            w_commit;
  logic            w_wr_in_range;
  logic [IDXW-1:0] w_wr_idx;
  logic            w_rd_in_range;
  logic [IDXW-1:0] w_rd_idx;
  logic            w_unused;

  assign AWREADY = ARESETn & ~r_aw_held & ~r_bvalid;
  assign WREADY  = ARESETn & ~r_w_held & ~r_bvalid;
  assign ARREADY = ARESETn & ~r_rvalid;

  assign w_aw_hs  = AWVALID & AWREADY;
  assign w_w_hs   = WVALID & WREADY;
  assign w_ar_hs  = ARVALID & ARREADY;
  assign w_commit = r_aw_held & r_w_held;

  assign w_wr_in_range = addr_in_range(r_awaddr);
  assign w_wr_idx      = addr_index(r_awaddr);
  assign w_rd_in_range = addr_in_range(ARADDR);
  assign w_rd_idx      = addr_index(ARADDR);

  // Protection bits and sub-word address bits carry no meaning here.
  assign w_unused = ^{AWPROT, ARPROT, r_awaddr[OFFS-1:0], ARADDR[OFFS-1:0]};

  assign BVALID     = r_bvalid;
  assign BRESP      = r_bresp;
  assign RVALID     = r_rvalid;
  assign RRESP      = r_rresp;
  assign RDATA      = r_rdata;
  assign regs_o     = r_regs;
  assign wr_pulse_o = r_wr_pulse;

  // Write address/data capture; both holds drop together at commit.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= {ADDR_WIDTH{1'b0}};
      r_wdata   <= {DATA_WIDTH{1'b0}};
      r_wstrb   <= {STRB_WIDTH{1'b0}};
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= AWADDR;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= WDATA;
        r_wstrb  <= WSTRB;
      end
    end
  end

  // Register file byte-lane update and per-register write strobe.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_regs     <= {(NUM_REGS*DATA_WIDTH){1'b0}};
      r_wr_pulse <= {NUM_REGS{1'b0}};
    end else begin
      r_wr_pulse <= {NUM_REGS{1'b0}};
      if (w_commit && w_wr_in_range) begin
        r_wr_pulse[w_wr_idx] <= 1'b1;
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (r_wstrb[b]) begin
            r_regs[w_wr_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Write response channel.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_bvalid && BREADY) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read channel; sampling r_regs here yields the pre-write value on a same-edge commit.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= {DATA_WIDTH{1'b0}};
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      if (w_rd_in_range) begin
        r_rdata <= r_regs[w_rd_idx];
        r_rresp <= RESP_OKAY;
      end else begin
        r_rdata <= {DATA_WIDTH{1'b0}};
        r_rresp <= RESP_SLVERR;
      end
    end else if (r_rvalid && RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave (32-bit data, 8 registers).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_axi4lite_reg_slave;

  logic         ACLK;
  logic         ARESETn;
  logic [31:0]  AWADDR;
  logic [2:0]   AWPROT;
  logic         AWVALID;
  logic         AWREADY;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         WVALID;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY;
  logic [31:0]  ARADDR;
  logic [2:0]   ARPROT;
  logic         ARVALID;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY;
  logic [255:0] regs_o;
  logic [7:0]   wr_pulse_o;

  int n_cmp;
  int n_err;
  logic [31:0] exp_r [8];

  axi4lite_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    logic [255:0] e;
    for (int i = 0; i < 8; i++) e[i*32 +: 32] = exp_r[i];
    n_cmp++;
    assert (regs_o === e) else begin
      n_err++;
      $error("FAIL %s: observed 0x%064h expected 0x%064h", tag, regs_o, e);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk1({pfx, "_awready"}, AWREADY, 1'b0);
    chk1({pfx, "_wready"}, WREADY, 1'b0);
    chk1({pfx, "_arready"}, ARREADY, 1'b0);
    chk1({pfx, "_bvalid"}, BVALID, 1'b0);
    chk1({pfx, "_rvalid"}, RVALID, 1'b0);
    chk2({pfx, "_bresp"}, BRESP, 2'b00);
    chk2({pfx, "_rresp"}, RRESP, 2'b00);
    chk32({pfx, "_rdata"}, RDATA, 32'h0);
    chk8({pfx, "_wr_pulse"}, wr_pulse_o, 8'h00);
    chk_regs({pfx, "_regs"});
  endtask

  task automatic b_handshake();
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
  endtask

  task automatic r_handshake();
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 8; i++) exp_r[i] = 32'h0;
    ARESETn = 1'b0;
    AWADDR = 32'h0; AWPROT = 3'b000; AWVALID = 1'b0;
    WDATA = 32'h0; WSTRB = 4'h0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = 32'h0; ARPROT = 3'b000; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset state and READY after release
    repeat (3) tick();
    chk_all_zero("rst");
    ARESETn = 1'b1;
    #1;
    chk1("rel_awready", AWREADY, 1'b1);
    chk1("rel_wready", WREADY, 1'b1);
    chk1("rel_arready", ARREADY, 1'b1);

    // AW and W in the same cycle to reg1
    AWADDR = 32'h04; AWVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk1("t1_bvalid_held", BVALID, 1'b0);
    chk1("t1_awready_held", AWREADY, 1'b0);
    chk1("t1_wready_held", WREADY, 1'b0);
    tick();
    exp_r[1] = 32'hDEADBEEF;
    chk1("t1_bvalid", BVALID, 1'b1);
    chk2("t1_bresp", BRESP, 2'b00);
    chk8("t1_pulse", wr_pulse_o, 8'h02);
    chk_regs("t1_regs");
    tick();
    chk8("t1_pulse_end", wr_pulse_o, 8'h00);
    chk1("t1_bvalid_hold", BVALID, 1'b1);
    b_handshake();
    chk1("t1_bvalid_clr", BVALID, 1'b0);
    chk1("t1_awready_back", AWREADY, 1'b1);

    // W byte 0 three cycles ahead of AW
    WDATA = 32'h000000AA; WSTRB = 4'h1; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    chk1("t2_wready_held", WREADY, 1'b0);
    chk1("t2_awready_free", AWREADY, 1'b1);
    tick();
    tick();
    AWADDR = 32'h04; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    chk1("t2_bvalid_pre", BVALID, 1'b0);
    tick();
    exp_r[1] = 32'hDEADBEAA;
    chk1("t2_bvalid", BVALID, 1'b1);
    chk8("t2_pulse", wr_pulse_o, 8'h02);
    chk_regs("t2_regs");
    b_handshake();

    // Out-of-range write and reads, plus range boundaries
    AWADDR = 32'h40; AWVALID = 1'b1; WDATA = 32'h1; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    chk1("t3_bvalid", BVALID, 1'b1);
    chk2("t3_bresp", BRESP, 2'b10);
    chk8("t3_pulse", wr_pulse_o, 8'h00);
    chk_regs("t3_regs");
    tick();
    chk8("t3_pulse_next", wr_pulse_o, 8'h00);
    b_handshake();
    ARADDR = 32'h40; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    chk1("t3_rvalid", RVALID, 1'b1);
    chk32("t3_rdata", RDATA, 32'h0);
    chk2("t3_rresp", RRESP, 2'b10);
    chk1("t3_arready_busy", ARREADY, 1'b0);
    tick();
    chk1("t3_rvalid_hold", RVALID, 1'b1);
    chk2("t3_rresp_hold", RRESP, 2'b10);
    r_handshake();
    chk1("t3_rvalid_clr", RVALID, 1'b0);
    chk1("t3_arready_back", ARREADY, 1'b1);
    ARADDR = 32'h07; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    chk32("t3_rd07_data", RDATA, 32'hDEADBEAA);
    chk2("t3_rd07_resp", RRESP, 2'b00);
    r_handshake();
    ARADDR = 32'h1C; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    chk2("t3_rd1c_resp", RRESP, 2'b00);
    r_handshake();
    ARADDR = 32'h20; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    chk2("t3_rd20_resp", RRESP, 2'b10);
    r_handshake();

    // B stalled for 5 cycles with a new write waiting
    AWADDR = 32'h0C; AWVALID = 1'b1; WDATA = 32'h11223344; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    exp_r[3] = 32'h11223344;
    AWADDR = 32'h10; AWVALID = 1'b1; WDATA = 32'hA5A5A5A5; WSTRB = 4'h3; WVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk1("t4_bvalid_stall", BVALID, 1'b1);
      chk2("t4_bresp_stall", BRESP, 2'b00);
      chk1("t4_awready_stall", AWREADY, 1'b0);
      chk1("t4_wready_stall", WREADY, 1'b0);
      tick();
    end
    b_handshake();
    chk1("t4_bvalid_clr", BVALID, 1'b0);
    chk1("t4_awready_open", AWREADY, 1'b1);
    chk1("t4_wready_open", WREADY, 1'b1);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk1("t4_awready_taken", AWREADY, 1'b0);
    chk1("t4_wready_taken", WREADY, 1'b0);
    tick();
    exp_r[4] = 32'h0000A5A5;
    chk1("t4_bvalid2", BVALID, 1'b1);
    chk8("t4_pulse2", wr_pulse_o, 8'h10);
    chk_regs("t4_regs");
    b_handshake();

    // Zero strobe still acknowledges and pulses
    AWADDR = 32'h0C; AWVALID = 1'b1; WDATA = 32'hFFFFFFFF; WSTRB = 4'h0; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    chk1("t5_bvalid", BVALID, 1'b1);
    chk2("t5_bresp", BRESP, 2'b00);
    chk8("t5_pulse", wr_pulse_o, 8'h08);
    chk_regs("t5_regs");
    b_handshake();

    // Read coinciding with a commit to the same register
    AWADDR = 32'h08; AWVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 32'h08; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    exp_r[2] = 32'h12345678;
    chk1("t6_rvalid", RVALID, 1'b1);
    chk32("t6_rdata_old", RDATA, 32'h0);
    chk1("t6_bvalid", BVALID, 1'b1);
    chk_regs("t6_regs");
    RREADY = 1'b1; BREADY = 1'b1;
    tick();
    RREADY = 1'b0; BREADY = 1'b0;
    chk1("t6_rvalid_clr", RVALID, 1'b0);
    chk1("t6_bvalid_clr", BVALID, 1'b0);
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    chk32("t6_rdata_new", RDATA, 32'h12345678);
    r_handshake();

    // Reset while an AW is held and a read response is pending
    AWADDR = 32'h14; AWVALID = 1'b1; ARADDR = 32'h04; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; ARVALID = 1'b0;
    chk1("t7_awready_held", AWREADY, 1'b0);
    chk1("t7_rvalid", RVALID, 1'b1);
    chk32("t7_rdata", RDATA, 32'hDEADBEAA);
    ARESETn = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) exp_r[i] = 32'h0;
    chk_all_zero("t7_inrst");
    tick();
    tick();
    ARESETn = 1'b1;
    #1;
    chk1("t7_awready_rel", AWREADY, 1'b1);
    WDATA = 32'h99; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    tick();
    tick();
    chk1("t7_no_bvalid", BVALID, 1'b0);
    chk1("t7_wready_held", WREADY, 1'b0);
    chk8("t7_no_pulse", wr_pulse_o, 8'h00);
    chk_regs("t7_regs");
    ARADDR = 32'h04; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    chk32("t7_rd_reg1", RDATA, 32'h0);
    chk2("t7_rd_resp", RRESP, 2'b00);
    r_handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
